// File: rtl/stepper_motion_ctrl.sv
// ============================================================================
// stepper_motion_ctrl : two-axis step/dir sequencer with soft limits and homing
// Rev 1.0
// ============================================================================
`default_nettype none

module stepper_axis #(
  parameter int TICK_DIV  = 100,
  parameter int PULSE_W   = 50,
  parameter int SETUP_CYC = 10,
  parameter int POS_MAX   = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        home,
  input  logic [15:0] speed,
  input  logic        dir_req,
  output logic        step,
  output logic        dir,
  output logic [31:0] pos,
  output logic        busy,
  output logic        at_limit
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [31:0] C_POS_MAX   = 32'(POS_MAX);
  localparam logic [15:0] C_SETUP_LD  = 16'(SETUP_CYC - 1);
  localparam logic [23:0] C_PULSE_W   = 24'(PULSE_W);
  localparam logic [23:0] C_MIN_T     = 24'(PULSE_W + 1);
  localparam logic [23:0] C_TICK_DIV  = 24'(TICK_DIV);

  state_t      state_q, state_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic [31:0] pos_q, pos_d;
  logic        busy_q, busy_d;
  logic        at_limit_q, at_limit_d;
  logic [15:0] setup_q, setup_d;
  logic [23:0] pcnt_q, pcnt_d;
  logic [23:0] period_q, period_d;

  logic [23:0] w_period;
  logic [23:0] w_target;
  logic        w_blocked;
  logic        w_rise;

  always_comb begin
    w_period  = 24'(speed) * C_TICK_DIV;
    w_target  = (period_q > C_MIN_T) ? period_q : C_MIN_T;
    w_blocked = (dir_req && (pos_q == C_POS_MAX)) || (!dir_req && (pos_q == 32'd0));

    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    pos_d    = pos_q;
    setup_d  = setup_q;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    w_rise   = 1'b0;

    case (state_q)
      S_IDLE: begin
        step_d = 1'b0;
        if (enable && (speed != 16'd0) && !w_blocked) begin
          dir_d   = dir_req;
          setup_d = C_SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_q == 16'd0) begin
          period_d = w_period;
          w_rise   = 1'b1;
        end else begin
          setup_d = setup_q - 16'd1;
        end
      end
      S_PULSE: begin
        pcnt_d = pcnt_q + 24'd1;
        if (pcnt_q >= C_PULSE_W) begin
          step_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: begin
        pcnt_d = pcnt_q + 24'd1;
        if (pcnt_q >= w_target) begin
          if ((speed == 16'd0) || w_blocked) begin
            state_d = S_IDLE;
          end else if (dir_req != dir_q) begin
            dir_d   = dir_req;
            setup_d = C_SETUP_LD;
            state_d = S_SETUP;
          end else begin
            period_d = w_period;
            w_rise   = 1'b1;
          end
        end
      end
    endcase

    // Step rise and position move share one edge; saturate so homing mid-move cannot wrap.
    if (w_rise) begin
      state_d = S_PULSE;
      step_d  = 1'b1;
      pcnt_d  = 24'd1;
      if (dir_d && (pos_q != C_POS_MAX)) begin
        pos_d = pos_q + 32'd1;
      end else if (!dir_d && (pos_q != 32'd0)) begin
        pos_d = pos_q - 32'd1;
      end
    end

    if (!enable) begin
      state_d = S_IDLE;
      step_d  = 1'b0;
      pos_d   = pos_q;
    end

    if (home) begin
      pos_d = 32'd0;
    end

    busy_d     = (state_d != S_IDLE);
    at_limit_d = w_blocked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= 32'd0;
      busy_q     <= 1'b0;
      at_limit_q <= 1'b0;
      setup_q    <= 16'd0;
      pcnt_q     <= 24'd0;
      period_q   <= 24'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      busy_q     <= busy_d;
      at_limit_q <= at_limit_d;
      setup_q    <= setup_d;
      pcnt_q     <= pcnt_d;
      period_q   <= period_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign pos      = pos_q;
  assign busy     = busy_q;
  assign at_limit = at_limit_q;

endmodule

module stepper_motion_ctrl #(
  parameter int TICK_DIV  = 100,
  parameter int PULSE_W   = 50,
  parameter int SETUP_CYC = 10,
  parameter int X_MAX     = 20000,
  parameter int Y_MAX     = 20000
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        enable,
  input  logic        home,
  input  logic [31:0] xSpeed,
  input  logic [31:0] xDirection,
  input  logic [31:0] ySpeed,
  input  logic [31:0] yDirection,
  output logic        x_step,
  output logic        x_dir,
  output logic        y_step,
  output logic        y_dir,
  output logic [31:0] currentX,
  output logic [31:0] currentY,
  output logic        x_busy,
  output logic        y_busy,
  output logic        x_at_limit,
  output logic        y_at_limit
);

  // Upper register bits carry no meaning for the sequencer.
  logic unused_bits;
  assign unused_bits = ^{xSpeed[31:16], ySpeed[31:16], xDirection[31:1], yDirection[31:1]};

  stepper_axis #(
    .TICK_DIV (TICK_DIV),
    .PULSE_W  (PULSE_W),
    .SETUP_CYC(SETUP_CYC),
    .POS_MAX  (X_MAX)
  ) u_axis_x (
    .clk     (clock),
    .rst     (ctrl_reset),
    .enable  (enable),
    .home    (home),
    .speed   (xSpeed[15:0]),
    .dir_req (xDirection[0]),
    .step    (x_step),
    .dir     (x_dir),
    .pos     (currentX),
    .busy    (x_busy),
    .at_limit(x_at_limit)
  );

  stepper_axis #(
    .TICK_DIV (TICK_DIV),
    .PULSE_W  (PULSE_W),
    .SETUP_CYC(SETUP_CYC),
    .POS_MAX  (Y_MAX)
  ) u_axis_y (
    .clk     (clock),
    .rst     (ctrl_reset),
    .enable  (enable),
    .home    (home),
    .speed   (ySpeed[15:0]),
    .dir_req (yDirection[0]),
    .step    (y_step),
    .dir     (y_dir),
    .pos     (currentY),
    .busy    (y_busy),
    .at_limit(y_at_limit)
  );

endmodule

`default_nettype wire
